// File: rtl/fpu_arb_pkg.sv
// Shared constants and width helpers for the FP-unit arbiter.
package fpu_arb_pkg;

  localparam int DATA_WIDTH_DEFAULT = 32;

  // Distance between neighbouring requester slices in the packed operand buses
  // for the default build; the top derives its own stride from DATA_WIDTH.
  localparam int REQ_STRIDE = DATA_WIDTH_DEFAULT;

  function automatic int tag_width(input int num_req);
    return (num_req > 1) ? $clog2(num_req) : 1;
  endfunction

  function automatic int cnt_width(input int max_out);
    return $clog2(max_out + 1);
  endfunction

endpackage

// File: rtl/fpu_arb_tag_fifo.sv
// Ownership tag FIFO: records which requester issued each in-flight operation.
// Push and pop in the same cycle are both honoured, including at full.
module fpu_arb_tag_fifo
  import fpu_arb_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             empty,
  output logic             full
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = cnt_width(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             push_ok, pop_ok;

  assign empty    = (cnt_q == '0);
  assign full     = (cnt_q == CNT_W'(DEPTH));
  assign pop_data = mem_q[rd_ptr_q];

  // A full FIFO still takes a push when the same cycle frees a slot.
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({push_ok, pop_ok})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/fpu_unit_arbiter.sv
// Shares one pipelined FP unit between NUM_REQ requesters with credit-limited issue
// and in-order result routing. Define FPU_ARB_FIXED_PRIORITY_EN for lowest-index-wins.
module fpu_unit_arbiter
  import fpu_arb_pkg::*;
#(
  parameter int NUM_REQ         = 2,
  parameter int DATA_WIDTH      = DATA_WIDTH_DEFAULT,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                          clkIn,
  input  logic                          rstIn,
  input  logic [NUM_REQ-1:0]            reqValidIn,
  output logic [NUM_REQ-1:0]            reqReadyOut,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] reqDataAIn,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] reqDataBIn,
  output logic [NUM_REQ-1:0]            rspValidOut,
  output logic [DATA_WIDTH-1:0]         rspDataOut,
  output logic                          unitValidOut,
  output logic [DATA_WIDTH-1:0]         unitDataAOut,
  output logic [DATA_WIDTH-1:0]         unitDataBOut,
  input  logic                          unitValidIn,
  input  logic [DATA_WIDTH-1:0]         unitDataIn,
  output logic                          busyOut,
  output logic                          errorOut
);

  localparam int TAG_WIDTH = tag_width(NUM_REQ);
  localparam int CNT_WIDTH = cnt_width(MAX_OUTSTANDING);
  localparam int STRIDE    = DATA_WIDTH;

  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic                  unit_valid_q, unit_valid_d;
  logic [DATA_WIDTH-1:0] unit_a_q, unit_a_d;
  logic [DATA_WIDTH-1:0] unit_b_q, unit_b_d;
  logic [NUM_REQ-1:0]    rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic                  err_q, err_d;

  logic                  credit_ok;
  logic                  grant_found;
  logic [TAG_WIDTH-1:0]  grant_idx;
  logic [NUM_REQ-1:0]    grant;
  logic                  accept;
  logic                  fifo_pop;
  logic                  fifo_empty;
  logic                  fifo_full;
  logic [TAG_WIDTH-1:0]  fifo_tag;

  assign credit_ok = !rstIn && !fifo_full && (cnt_q < CNT_WIDTH'(MAX_OUTSTANDING));

`ifdef FPU_ARB_FIXED_PRIORITY_EN
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!grant_found && reqValidIn[i]) begin
        grant_found = 1'b1;
        grant_idx   = TAG_WIDTH'(i);
      end
    end
  end
`else
  logic [TAG_WIDTH-1:0] ptr_q, ptr_d;

  function automatic logic [TAG_WIDTH-1:0] rr_pick(input logic [TAG_WIDTH-1:0] base,
                                                   input int off);
    int s;
    s = int'(base) + off;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return TAG_WIDTH'(s);
  endfunction

  // Search starts just after the last winner, so it ends up with lowest priority.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (!grant_found && reqValidIn[rr_pick(ptr_q, k)]) begin
        grant_found = 1'b1;
        grant_idx   = rr_pick(ptr_q, k);
      end
    end
  end

  assign ptr_d = accept ? grant_idx : ptr_q;

  always_ff @(posedge clkIn) begin
    if (rstIn) ptr_q <= TAG_WIDTH'(NUM_REQ - 1);
    else       ptr_q <= ptr_d;
  end
`endif

  // Handshake: a requester holds reqValidIn and its operands until it sees
  // reqReadyOut; the operation is taken on the edge where both are high.
  assign grant       = (grant_found && credit_ok) ? (NUM_REQ'(1) << grant_idx) : '0;
  assign reqReadyOut = grant;
  assign accept      = |grant;

  // A result with nothing outstanding has no owner; it is dropped and flagged.
  assign fifo_pop = unitValidIn && !fifo_empty;

  fpu_arb_tag_fifo #(
    .DEPTH (MAX_OUTSTANDING),
    .WIDTH (TAG_WIDTH)
  ) u_tag_fifo (
    .clk       (clkIn),
    .rst       (rstIn),
    .push      (accept),
    .push_data (grant_idx),
    .pop       (fifo_pop),
    .pop_data  (fifo_tag),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

  always_comb begin
    unit_valid_d = accept;
    unit_a_d     = unit_a_q;
    unit_b_d     = unit_b_q;
    rsp_valid_d  = '0;
    rsp_data_d   = rsp_data_q;
    err_d        = err_q | (unitValidIn & fifo_empty);
    cnt_d        = cnt_q;
    if (accept) begin
      unit_a_d = reqDataAIn[int'(grant_idx)*STRIDE +: DATA_WIDTH];
      unit_b_d = reqDataBIn[int'(grant_idx)*STRIDE +: DATA_WIDTH];
    end
    if (fifo_pop) begin
      rsp_valid_d = NUM_REQ'(1) << fifo_tag;
      rsp_data_d  = unitDataIn;
    end
    case ({accept, fifo_pop})
      2'b10:   cnt_d = cnt_q + CNT_WIDTH'(1);
      2'b01:   cnt_d = cnt_q - CNT_WIDTH'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clkIn) begin
    if (rstIn) begin
      cnt_q        <= '0;
      unit_valid_q <= 1'b0;
      unit_a_q     <= '0;
      unit_b_q     <= '0;
      rsp_valid_q  <= '0;
      rsp_data_q   <= '0;
      err_q        <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      unit_valid_q <= unit_valid_d;
      unit_a_q     <= unit_a_d;
      unit_b_q     <= unit_b_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_data_q   <= rsp_data_d;
      err_q        <= err_d;
    end
  end

  assign unitValidOut = unit_valid_q;
  assign unitDataAOut = unit_a_q;
  assign unitDataBOut = unit_b_q;
  assign rspValidOut  = rsp_valid_q;
  assign rspDataOut   = rsp_data_q;
  assign busyOut      = (cnt_q != '0);
  assign errorOut     = err_q;

endmodule

// File: tb/tb_fpu_unit_arbiter.sv
// Bench for fpu_unit_arbiter: directed scenarios plus random traffic against a
// queue-based reference model and a stand-in pipelined FP unit.
module tb_fpu_unit_arbiter;

  localparam int NR   = 2;
  localparam int DW   = 32;
  localparam int MAXO = 4;

  logic             clk = 1'b0;
  logic             rstIn;
  logic [NR-1:0]    reqValidIn;
  logic [NR-1:0]    reqReadyOut;
  logic [NR*DW-1:0] reqDataAIn;
  logic [NR*DW-1:0] reqDataBIn;
  logic [NR-1:0]    rspValidOut;
  logic [DW-1:0]    rspDataOut;
  logic             unitValidOut;
  logic [DW-1:0]    unitDataAOut;
  logic [DW-1:0]    unitDataBOut;
  logic             unitValidIn;
  logic [DW-1:0]    unitDataIn;
  logic             busyOut;
  logic             errorOut;

  fpu_unit_arbiter #(
    .NUM_REQ         (NR),
    .DATA_WIDTH      (DW),
    .MAX_OUTSTANDING (MAXO)
  ) dut (
    .clkIn        (clk),
    .rstIn        (rstIn),
    .reqValidIn   (reqValidIn),
    .reqReadyOut  (reqReadyOut),
    .reqDataAIn   (reqDataAIn),
    .reqDataBIn   (reqDataBIn),
    .rspValidOut  (rspValidOut),
    .rspDataOut   (rspDataOut),
    .unitValidOut (unitValidOut),
    .unitDataAOut (unitDataAOut),
    .unitDataBOut (unitDataBOut),
    .unitValidIn  (unitValidIn),
    .unitDataIn   (unitDataIn),
    .busyOut      (busyOut),
    .errorOut     (errorOut)
  );

  // clock
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // requester state: an operation stays posted until accepted (or dropped)
  bit          req_pend [NR];
  logic [31:0] req_a    [NR];
  logic [31:0] req_b    [NR];

  // reference model: expected owner/result per in-flight op, in issue order
  logic [39:0] exp_q [$];
  int          rr_last;
  logic        exp_err;

  // stand-in FP unit: results with their due cycle
  logic [31:0] uq_res [$];
  int          uq_due [$];
  int          unit_lat;
  bit          unit_auto;
  bit          unit_release;
  bit          spurious_req;

  int          cyc;
  int          last_acc;
  int          acc_count;
  int          issue_cyc;
  int          rsp_cyc;
  logic [NR-1:0] rsp_vec;
  logic [31:0] rsp_data_seen;
  int          grants [6];
  int          n_grant;
  int          t0;

  // Stand-in unit function; picked so that 3.0 x 2.0 gives the encoding of 6.0.
  function automatic logic [31:0] unit_fn(input logic [31:0] a, input logic [31:0] b);
    return a ^ b ^ 32'h4080_0000;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic post(input int i, input logic [31:0] a, input logic [31:0] b);
    req_pend[i] = 1'b1;
    req_a[i]    = a;
    req_b[i]    = b;
  endtask

  task automatic post_rand_idle();
    for (int i = 0; i < NR; i++)
      if (!req_pend[i]) post(i, $urandom, $urandom);
  endtask

  task automatic drop_all();
    for (int i = 0; i < NR; i++) req_pend[i] = 1'b0;
  endtask

  // One clock cycle: drive inputs, predict, advance, compare.
  task automatic cycle();
    int            g;
    int            tmp;
    bit            pop;
    bit            rst_now;
    bit            issue_now;
    logic [31:0]   issue_res;
    logic [39:0]   e;
    logic [NR-1:0] exp_ready;
    logic          exp_uv;
    logic [31:0]   exp_ua;
    logic [31:0]   exp_ub;
    logic [NR-1:0] exp_rv;
    logic [31:0]   exp_rd;
    exp_ua = '0;
    exp_ub = '0;
    exp_rd = '0;
    for (int i = 0; i < NR; i++) begin
      reqValidIn[i]          = req_pend[i];
      reqDataAIn[i*DW +: DW] = req_a[i];
      reqDataBIn[i*DW +: DW] = req_b[i];
    end
    unitValidIn = 1'b0;
    unitDataIn  = '0;
    if (spurious_req) begin
      unitValidIn  = 1'b1;
      unitDataIn   = $urandom;
      spurious_req = 1'b0;
    end else if (uq_res.size() > 0 && (unit_auto ? (uq_due[0] <= cyc) : unit_release)) begin
      unitValidIn = 1'b1;
      unitDataIn  = uq_res.pop_front();
      tmp         = uq_due.pop_front();
    end
    unit_release = 1'b0;
    #1;
    rst_now   = rstIn;
    issue_now = unitValidOut;
    issue_res = unit_fn(unitDataAOut, unitDataBOut);
    g = -1;
    if (!rst_now && exp_q.size() < MAXO) begin
`ifdef FPU_ARB_FIXED_PRIORITY_EN
      for (int k = 0; k < NR; k++)
        if (g < 0 && req_pend[k]) g = k;
`else
      for (int k = 1; k <= NR; k++)
        if (g < 0 && req_pend[(rr_last + k) % NR]) g = (rr_last + k) % NR;
`endif
    end
    exp_ready = (g >= 0) ? (NR'(1) << g) : '0;
    chk("ready", reqReadyOut, exp_ready);
    last_acc = g;
    exp_rv   = '0;
    exp_uv   = 1'b0;
    if (rst_now) begin
      exp_q.delete();
      rr_last = NR - 1;
      exp_err = 1'b0;
    end else begin
      pop = unitValidIn && (exp_q.size() > 0);
      if (unitValidIn && exp_q.size() == 0) exp_err = 1'b1;
      if (pop) begin
        e      = exp_q.pop_front();
        exp_rv = NR'(1) << e[39:32];
        exp_rd = e[31:0];
      end
      if (g >= 0) begin
        exp_uv = 1'b1;
        exp_ua = req_a[g];
        exp_ub = req_b[g];
        exp_q.push_back({8'(g), unit_fn(req_a[g], req_b[g])});
        rr_last     = g;
        req_pend[g] = 1'b0;
        acc_count++;
      end
    end
    @(posedge clk);
    #1;
    // the unit shares rstIn: a reset edge flushes it and swallows that cycle's issue
    if (rst_now) begin
      uq_res.delete();
      uq_due.delete();
    end else if (issue_now) begin
      uq_res.push_back(issue_res);
      uq_due.push_back(cyc + unit_lat);
    end
    cyc++;
    chk("unit_valid", unitValidOut, exp_uv);
    if (exp_uv) begin
      chk("unit_a", unitDataAOut, exp_ua);
      chk("unit_b", unitDataBOut, exp_ub);
    end
    chk("rsp_valid", rspValidOut, exp_rv);
    if (exp_rv != '0) chk("rsp_data", rspDataOut, exp_rd);
    if (rst_now) begin
      chk("rst_unit_a", unitDataAOut, 0);
      chk("rst_rsp_data", rspDataOut, 0);
    end
    chk("busy", busyOut, exp_q.size() != 0);
    chk("error", errorOut, exp_err);
    if (unitValidOut) issue_cyc = cyc;
    if (rspValidOut != '0) begin
      rsp_cyc       = cyc;
      rsp_vec       = rspValidOut;
      rsp_data_seen = rspDataOut;
    end
  endtask

  task automatic do_reset();
    drop_all();
    rstIn = 1'b1;
    cycle();
    rstIn = 1'b0;
  endtask

  task automatic drain();
    drop_all();
    unit_auto = 1'b1;
    for (int n = 0; n < 80 && (exp_q.size() > 0 || uq_res.size() > 0); n++) cycle();
    cycle();
    chk("drain_busy", busyOut, 0);
  endtask

  initial begin
    rstIn = 1'b1; reqValidIn = '0; reqDataAIn = '0; reqDataBIn = '0;
    unitValidIn = 1'b0; unitDataIn = '0;
    drop_all();
    for (int i = 0; i < NR; i++) begin req_a[i] = '0; req_b[i] = '0; end
    rr_last = NR - 1; exp_err = 1'b0; cyc = 0;
    unit_lat = 3; unit_auto = 1'b1; unit_release = 1'b0; spurious_req = 1'b0;
    acc_count = 0; issue_cyc = -1; rsp_cyc = -1; rsp_vec = '0; rsp_data_seen = '0;

    // reset, with a request already waiting: it must not be granted yet
    cycle();
    post(0, 32'h4040_0000, 32'h4000_0000);
    cycle();
    chk("rst_ready", reqReadyOut, 0);
    rstIn = 1'b0;

    // single op, latency 3
    cycle();
    chk("single_acc_idx", last_acc, 0);
    t0 = cyc - 1;
    for (int n = 0; n < 15 && rsp_cyc < 0; n++) cycle();
    chk("single_issue_lat", issue_cyc - t0, 1);
    chk("single_rsp_lat", rsp_cyc - t0, 5);
    chk("single_rsp_vec", rsp_vec, 2'b01);
    chk("single_rsp_data", rsp_data_seen, 32'h40C0_0000);
    chk("single_busy_after", busyOut, 0);

    // contention from a fresh pointer
    do_reset();
    n_grant = 0;
    for (int n = 0; n < 40 && n_grant < 6; n++) begin
      post_rand_idle();
      cycle();
      if (last_acc >= 0) begin grants[n_grant] = last_acc; n_grant++; end
    end
    for (int j = 0; j < 6; j++) begin
`ifdef FPU_ARB_FIXED_PRIORITY_EN
      chk("contend_grant", grants[j], 0);
`else
      chk("contend_grant", grants[j], j % 2);
`endif
    end
    drain();

    // credit saturation with the unit stalled
    unit_auto = 1'b0; acc_count = 0;
    for (int n = 0; n < 10; n++) begin post_rand_idle(); cycle(); end
    chk("sat_accepts", acc_count, 4);
    chk("sat_ready_low", reqReadyOut, 0);
    acc_count = 0; unit_release = 1'b1;
    for (int n = 0; n < 6; n++) begin post_rand_idle(); cycle(); end
    chk("sat_one_more", acc_count, 1);

    // bring count to 2, then accept and return together
    drop_all();
    unit_release = 1'b1; cycle();
    unit_release = 1'b1; cycle();
    chk("simul_busy", busyOut, 1);
    post(0, $urandom, $urandom);
    unit_release = 1'b1;
    cycle();
    chk("simul_accept", last_acc >= 0, 1);
    chk("simul_rsp", rspValidOut != '0, 1);
    acc_count = 0;
    for (int n = 0; n < 6; n++) begin post_rand_idle(); cycle(); end
    chk("simul_count_held", acc_count, 2);
    drain();

    // spurious result
    spurious_req = 1'b1;
    cycle();
    chk("spur_err", errorOut, 1);
    chk("spur_rsp", rspValidOut, 0);
    repeat (3) cycle();
    chk("spur_err_held", errorOut, 1);
    do_reset();
    chk("spur_err_clr", errorOut, 0);

    // reset with three ops in flight
    unit_auto = 1'b0; acc_count = 0;
    for (int n = 0; n < 10 && acc_count < 3; n++) begin post_rand_idle(); cycle(); end
    chk("mid_three", acc_count, 3);
    do_reset();
    chk("mid_busy", busyOut, 0);
    unit_auto = 1'b1;
    post(0, $urandom, $urandom);
    post(1, $urandom, $urandom);
    cycle();
    chk("mid_first_grant", last_acc, 0);
    drain();

    // random traffic at two unit latencies
    for (int p = 0; p < 2; p++) begin
      unit_lat = (p == 0) ? 1 : 5;
      for (int n = 0; n < 200; n++) begin
        for (int i = 0; i < NR; i++)
          if (!req_pend[i] && $urandom_range(0, 2) == 0) post(i, $urandom, $urandom);
        unit_auto = ($urandom_range(0, 3) != 0);
        cycle();
      end
      drain();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
